// File: rtl/mult_arb_pkg.sv
// Shared constants and types for the multiplier arbiter slice.
// Defaults here seed the parameters of mult_arbiter.
package mult_arb_pkg;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 32;
    localparam int MUL_LATENCY = 2;
    localparam int IDX_W       = $clog2(NUM_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } mult_tag_t;

    // Index width for a requester count, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_arb_pick.sv
// One-hot pick of a single eligible requester.
// MULT_ARB_RR_EN: round-robin from ptr_i; otherwise lowest index wins.
module mult_arb_pick
    import mult_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig_i,
`ifdef MULT_ARB_RR_EN
    input  logic [IW-1:0] ptr_i,
`endif
    output logic [N-1:0]  gnt_o,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

`ifdef MULT_ARB_RR_EN
    // Search upward from the pointer, wrapping, first hit wins.
    always_comb begin
        int j;
        gnt_o = '0;
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && elig_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters.
// MULT_ARB_RR_EN selects round-robin; default is fixed priority.
module mult_arbiter #(
    parameter int NUM_REQ     = mult_arb_pkg::NUM_REQ,
    parameter int WIDTH       = mult_arb_pkg::WIDTH,
    parameter int MUL_LATENCY = mult_arb_pkg::MUL_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [NUM_REQ*2*WIDTH-1:0]   rsp_p,
    output logic [WIDTH-1:0]             mul_a,
    output logic [WIDTH-1:0]             mul_b,
    input  logic [2*WIDTH-1:0]           mul_p,
    output logic                         busy
);
    import mult_arb_pkg::*;

    localparam int IW = idx_w(NUM_REQ);
    localparam int PW = 2 * WIDTH;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } tag_t;

    tag_t               tag_q [MUL_LATENCY];
    tag_t               tag_d;
    tag_t               last;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [PW-1:0]      slot_q [NUM_REQ];
    logic [NUM_REQ-1:0] inflight;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic               any;
    logic [IW-1:0]      widx;

    assign last = tag_q[MUL_LATENCY-1];

    // Requesters with a tag anywhere in the multiplier pipeline.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < MUL_LATENCY; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_q[s].valid && tag_q[s].idx == IW'(i))
                    inflight[i] = 1'b1;
            end
        end
    end

    // Reset gates eligibility so no grant leaks out while rst is low.
    assign pending = inflight | rsp_valid_q;
    assign elig    = req_valid & ~pending & {NUM_REQ{rst}};

`ifdef MULT_ARB_RR_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Pointer moves past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (any)
            ptr_d = (int'(widx) == NUM_REQ - 1) ? '0 : widx + 1'b1;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`endif

    mult_arb_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .elig_i (elig),
`ifdef MULT_ARB_RR_EN
        .ptr_i  (ptr_q),
`endif
        .gnt_o  (gnt),
        .any_o  (any),
        .idx_o  (widx)
    );

    assign req_ready = gnt;

    // AND-OR mux of the winner's operands; zero when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mul_a = mul_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
            mul_b = mul_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
        end
    end

    always_comb begin
        tag_d.valid = any;
        tag_d.idx   = widx;
    end

    // Tag pipeline mirrors the multiplier; it never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < MUL_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < MUL_LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Result slots: capture on the last tag stage, clear on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid_q[i] && rsp_ready[i])
                    rsp_valid_q[i] <= 1'b0;
                if (last.valid && last.idx == IW'(i)) begin
                    rsp_valid_q[i] <= 1'b1;
                    slot_q[i]      <= mul_p;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_p[g*PW +: PW] = slot_q[g];
    end

    assign rsp_valid = rsp_valid_q;

    // Busy while any tag flies or any product waits.
    always_comb begin
        busy = |rsp_valid_q;
        for (int s = 0; s < MUL_LATENCY; s++) busy = busy | tag_q[s].valid;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 2-stage multiplier model.
// Expectations follow MULT_ARB_RR_EN where the order differs.
module tb_mult_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [255:0] rsp_p;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [63:0]  mul_p;
    logic         busy;

    logic signed [63:0] p1, p2;

    int pass_n = 0;
    int fail_n = 0;
    int total_n = 0;

    logic [63:0] exp4 [4];
    logic [31:0] opa4 [4];
    logic [3:0]  expg;

`ifdef MULT_ARB_RR_EN
    localparam logic [3:0] FIRST  = 4'b1000;
    localparam logic [3:0] SECOND = 4'b0010;
    localparam int         FIRST_I = 3;
    localparam int         SECOND_I = 1;
`else
    localparam logic [3:0] FIRST  = 4'b0010;
    localparam logic [3:0] SECOND = 4'b1000;
    localparam int         FIRST_I = 1;
    localparam int         SECOND_I = 3;
`endif

    always #5 clk = ~clk;

    // External multiplier: product two cycles after operands.
    always @(posedge clk) begin
        p1 <= $signed(mul_a) * $signed(mul_b);
        p2 <= p1;
    end
    assign mul_p = p2;

    mult_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    function automatic logic [63:0] slot(input int i);
        return rsp_p[i*64 +: 64];
    endfunction

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        req_a     = '1;
        req_b     = '1;

        // Reset state, with requests asserted.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rspv", 64'(rsp_valid), 64'h0);
        chk("rst_rspp", 64'(|rsp_p), 64'h0);
        chk("rst_mula", 64'(mul_a), 64'h0);
        chk("rst_mulb", 64'(mul_b), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rst       = 1'b1;

        // Single op: -3 * 7 from requester 0.
        @(negedge clk);
        req_valid = 4'b0001;
        set_op(0, 32'hFFFF_FFFD, 32'd7);
        #1;
        chk("s_ready", 64'(req_ready), 64'h1);
        chk("s_mula", 64'(mul_a), 64'hFFFF_FFFD);
        chk("s_mulb", 64'(mul_b), 64'h7);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("s_c1_rspv", 64'(rsp_valid), 64'h0);
        chk("s_c1_busy", 64'(busy), 64'h1);
        chk("s_c1_mula", 64'(mul_a), 64'h0);
        @(negedge clk);
        #1;
        chk("s_c2_rspv", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        #1;
        chk("s_c3_rspv", 64'(rsp_valid), 64'h1);
        chk("s_c3_p", slot(0), 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        #1;
        chk("s_c4_rspv", 64'(rsp_valid), 64'h0);
        chk("s_c4_busy", 64'(busy), 64'h0);
        chk("s_c4_hold", slot(0), 64'hFFFF_FFFF_FFFF_FFEB);

        // Extremes on requesters 1 and 2.
        @(negedge clk);
        set_op(1, 32'h8000_0000, 32'h8000_0000);
        set_op(2, 32'h7FFF_FFFF, 32'h8000_0000);
        req_valid = 4'b0110;
        #1;
        chk("x_c0_ready", 64'(req_ready), 64'h2);
        chk("x_c0_mula", 64'(mul_a), 64'h8000_0000);
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chk("x_c1_ready", 64'(req_ready), 64'h4);
        chk("x_c1_mula", 64'(mul_a), 64'h7FFF_FFFF);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("x_c3_rspv", 64'(rsp_valid), 64'h2);
        chk("x_c3_p1", slot(1), 64'h4000_0000_0000_0000);
        @(negedge clk);
        #1;
        chk("x_c4_rspv", 64'(rsp_valid), 64'h4);
        chk("x_c4_p2", slot(2), 64'hC000_0000_8000_0000);
        @(negedge clk);
        #1;
        chk("x_c5_rspv", 64'(rsp_valid), 64'h0);
        chk("x_c5_hold", slot(1), 64'h4000_0000_0000_0000);

        // Reset one cycle after a grant drops the operation.
        @(negedge clk);
        set_op(3, 32'd5, 32'd6);
        req_valid = 4'b1000;
        #1;
        chk("r_c0_ready", 64'(req_ready), 64'h8);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
        #1;
        chk("r_c1_busy", 64'(busy), 64'h0);
        chk("r_c1_rspv", 64'(rsp_valid), 64'h0);
        chk("r_c1_rspp", 64'(|rsp_p), 64'h0);
        chk("r_c1_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 2; c < 6; c++) begin
            #1;
            chk($sformatf("r_c%0d_rspv", c), 64'(rsp_valid), 64'h0);
            chk($sformatf("r_c%0d_busy", c), 64'(busy), 64'h0);
            @(negedge clk);
        end

        // All four continuously requesting.
        exp4[0] = 64'd12;
        exp4[1] = 64'hFFFF_FFFF_FFFF_FFF6;
        exp4[2] = 64'h2_540B_E400;
        exp4[3] = 64'd1;
        opa4[0] = 32'd3;
        opa4[1] = 32'hFFFF_FFFE;
        opa4[2] = 32'd100000;
        opa4[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) set_op(i, opa4[i], 32'd0);
        set_op(0, opa4[0], 32'd4);
        set_op(1, opa4[1], 32'd5);
        set_op(2, opa4[2], 32'd100000);
        set_op(3, opa4[3], 32'hFFFF_FFFF);
        req_valid = 4'hF;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 5 && c <= 8) req_valid[c-5] = 1'b0;
            #1;
            if (c < 8) begin
                chk($sformatf("a_c%0d_ready", c), 64'(req_ready),
                    64'(4'b0001 << (c % 4)));
                chk($sformatf("a_c%0d_mula", c), 64'(mul_a),
                    64'(opa4[c % 4]));
            end
            if (c >= 3) begin
                chk($sformatf("a_c%0d_rspv", c), 64'(rsp_valid),
                    64'(4'b0001 << ((c - 3) % 4)));
                chk($sformatf("a_c%0d_p", c), slot((c - 3) % 4),
                    exp4[(c - 3) % 4]);
            end
        end
        @(negedge clk);
        #1;
        chk("a_idle_busy", 64'(busy), 64'h0);

        // Backpressure on requester 2 for 20 cycles.
        @(negedge clk);
        rsp_ready = 4'b1011;
        req_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 17) req_valid[0] = 1'b0;
            if (c == 18) req_valid[1] = 1'b0;
            #1;
            if (c % 4 == 2) expg = (c == 2) ? 4'b0100 : 4'b0000;
            else            expg = 4'b0001 << (c % 4);
            chk($sformatf("b_c%0d_ready", c), 64'(req_ready), 64'(expg));
            if (c >= 5) begin
                chk($sformatf("b_c%0d_rspv2", c), 64'(rsp_valid[2]), 64'h1);
                chk($sformatf("b_c%0d_p2", c), slot(2), exp4[2]);
            end
        end
        @(negedge clk);
        req_valid[3] = 1'b0;
        rsp_ready[2] = 1'b1;
        #1;
        chk("b_c20_ready", 64'(req_ready), 64'h0);
        chk("b_c20_rspv2", 64'(rsp_valid[2]), 64'h1);
        @(negedge clk);
        #1;
        chk("b_c21_ready", 64'(req_ready), 64'h4);
        chk("b_c21_rspv2", 64'(rsp_valid[2]), 64'h0);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("b_c24_rspv", 64'(rsp_valid), 64'h4);
        chk("b_c24_p2", slot(2), exp4[2]);
        @(negedge clk);
        #1;
        chk("b_c25_busy", 64'(busy), 64'h0);

        // Requesters 1 and 3 together.
        @(negedge clk);
        set_op(1, 32'd6, 32'd7);
        set_op(3, 32'hFFFF_FFFC, 32'd8);
        req_valid = 4'b1010;
        #1;
        chk("p_c0_ready", 64'(req_ready), 64'(FIRST));
        @(negedge clk);
        req_valid[FIRST_I] = 1'b0;
        #1;
        chk("p_c1_ready", 64'(req_ready), 64'(SECOND));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("p_c3_rspv", 64'(rsp_valid), 64'(FIRST));
        @(negedge clk);
        #1;
        chk("p_c4_rspv", 64'(rsp_valid), 64'(SECOND));
        chk("p_p1", slot(1), 64'd42);
        chk("p_p3", slot(3), 64'hFFFF_FFFF_FFFF_FFE0);
        if (SECOND_I == FIRST_I) chk("p_idx", 64'h0, 64'h1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
